// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory among NUM_REQ requesters.
// Optional MEM_ARB_LOCK_EN adds bus locking: a locked beat keeps the grant with its requester.
module mem_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr_i,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wdata_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]    req_wstrb_i,
    input  logic [NUM_REQ-1:0]                   req_lock_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]              mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH  = $clog2(NUM_REQ);

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [NUM_REQ-1:0]   eligible_c;
    logic                 grant_c;
    int unsigned          win_c;
    int unsigned          cand_c;

`ifdef MEM_ARB_LOCK_EN
    logic                 owner_valid_q;
    logic [PTR_WIDTH-1:0] owner_idx_q;

    // An active owner masks every other requester, even if the owner itself is idle.
    always_comb begin
        eligible_c = req_valid_i;
        if (owner_valid_q) begin
            eligible_c = req_valid_i & (NUM_REQ'(1) << owner_idx_q);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            owner_valid_q <= 1'b0;
            owner_idx_q   <= '0;
        end else if (grant_c) begin
            owner_valid_q <= 1'(req_lock_i >> win_c);
            owner_idx_q   <= PTR_WIDTH'(win_c);
        end
    end
`else
    logic unused_lock;

    assign eligible_c  = req_valid_i;
    assign unused_lock = ^req_lock_i;
`endif

    // First eligible requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_c = 1'b0;
        win_c   = 0;
        cand_c  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = (32'(ptr_q) + k) % NUM_REQ;
            if (!grant_c && |(eligible_c & (NUM_REQ'(1) << cand_c))) begin
                grant_c = 1'b1;
                win_c   = cand_c;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (grant_c) begin
            req_ready_o = NUM_REQ'(1) << win_c;
            mem_addr_o  = ADDR_WIDTH'(req_addr_i >> (win_c * ADDR_WIDTH));
            mem_we_o    = 1'(req_we_i >> win_c);
            mem_wdata_o = DATA_WIDTH'(req_wdata_i >> (win_c * DATA_WIDTH));
            mem_wstrb_o = STRB_WIDTH'(req_wstrb_i >> (win_c * STRB_WIDTH));
        end
    end

    // Response data is captured at the acceptance edge; writes answer with zero.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q       <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= req_ready_o;
            if (grant_c) begin
                ptr_q       <= PTR_WIDTH'((win_c + 1) % NUM_REQ);
                rsp_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
            end
        end
    end

endmodule
